// File: rtl/motor_ramp_pkg.sv
// Shared definitions for the motor slew-limiting stage and the PWM stage.
package motor_ramp_pkg;

  // Per-channel ramp FSM encoding.
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_BRAKE = 2'd1,
    ST_DEAD  = 2'd2
  } ch_state_t;

  // Default timing: PWM counter terminal value (also the duty ceiling),
  // largest duty change per PWM period, and dead periods before a reversal.
  localparam int DEF_PERIOD   = 250000;
  localparam int DEF_DUTY_W   = 20;
  localparam int DEF_STEP     = 12500;
  localparam int DEF_DEADTIME = 2;

  // Bridge direction with both legs off.
  localparam logic [1:0] DIR_OFF = 2'b00;

endpackage

// File: rtl/motor_ramp_channel.sv
// One slew-limited H-bridge channel: duty ramp, brake-to-zero and dead time
// before any direction change. Updates only on i_tick; i_estop acts at once.
module motor_ramp_channel
  import motor_ramp_pkg::*;
#(
  parameter int DUTY_W   = DEF_DUTY_W,
  parameter int STEP     = DEF_STEP,
  parameter int DEADTIME = DEF_DEADTIME  // must be at least 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_tick,
  input  logic              i_estop,
  input  logic [DUTY_W-1:0] i_tgt,     // already clamped to the ceiling
  input  logic [1:0]        i_dir,
  output logic [DUTY_W-1:0] o_duty,
  output logic [1:0]        o_dir,
  output logic [1:0]        o_state    // debug view of the FSM state
);

  localparam int CNT_W = $clog2(DEADTIME + 1);
  localparam logic [CNT_W-1:0]  DEAD_LAST = CNT_W'(DEADTIME - 1);
  localparam logic [DUTY_W:0]   STEP_X    = (DUTY_W + 1)'(STEP);
  localparam logic [DUTY_W-1:0] STEP_N    = STEP_X[DUTY_W-1:0];

  ch_state_t         r_state;
  logic [DUTY_W-1:0] r_duty;
  logic [1:0]        r_dir;
  logic [CNT_W-1:0]  r_dead_cnt;

  // Ramp arithmetic is done one bit wider so duty+STEP can never wrap.
  logic [DUTY_W:0]   w_duty_x;
  logic [DUTY_W:0]   w_tgt_x;
  logic [DUTY_W:0]   w_up;
  logic [DUTY_W:0]   w_gap;
  logic [DUTY_W-1:0] w_ramp;
  logic [DUTY_W-1:0] w_brake;

  // Next duty for a RUN tick (toward target, no overshoot) and a BRAKE tick (toward 0).
  always_comb begin
    w_duty_x = {1'b0, r_duty};
    w_tgt_x  = {1'b0, i_tgt};
    w_up     = w_duty_x + STEP_X;
    w_gap    = w_duty_x - w_tgt_x;
    w_ramp   = r_duty;
    if (w_duty_x < w_tgt_x) begin
      w_ramp = (w_up >= w_tgt_x) ? i_tgt : w_up[DUTY_W-1:0];
    end else if (w_duty_x > w_tgt_x) begin
      w_ramp = (w_gap <= STEP_X) ? i_tgt : (r_duty - STEP_N);
    end
    w_brake = (w_duty_x <= STEP_X) ? '0 : (r_duty - STEP_N);
  end

  // Channel FSM: reset beats estop, estop beats tick.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state    <= ST_RUN;
      r_duty     <= '0;
      r_dir      <= DIR_OFF;
      r_dead_cnt <= '0;
    end else if (i_estop) begin
      r_state    <= ST_DEAD;
      r_duty     <= '0;
      r_dir      <= DIR_OFF;
      r_dead_cnt <= '0;
    end else if (i_tick) begin
      case (r_state)
        ST_RUN: begin
          // A direction request never ramps; it first brakes to zero.
          if (i_dir != r_dir) begin
            r_state <= ST_BRAKE;
          end else begin
            r_duty <= w_ramp;
          end
        end
        ST_BRAKE: begin
          r_duty <= w_brake;
          if (w_brake == '0) begin
            r_dir      <= DIR_OFF;
            r_dead_cnt <= '0;
            r_state    <= ST_DEAD;
          end
        end
        ST_DEAD: begin
          // Direction is latched only at exit, so late dir changes win.
          if (r_dead_cnt == DEAD_LAST) begin
            r_dir      <= i_dir;
            r_dead_cnt <= '0;
            r_state    <= ST_RUN;
          end else begin
            r_dead_cnt <= r_dead_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state    <= ST_DEAD;
          r_duty     <= '0;
          r_dir      <= DIR_OFF;
          r_dead_cnt <= '0;
        end
      endcase
    end
  end

  assign o_duty  = r_duty;
  assign o_dir   = r_dir;
  assign o_state = r_state;

endmodule

// File: rtl/motor_ramp.sv
// Slew-limiting stage between steering logic and the PWM generator.
// Channel A owns dir bits [1:0] (ena), channel B owns [3:2] (enb).
module motor_ramp
  import motor_ramp_pkg::*;
#(
  parameter int PERIOD   = DEF_PERIOD,
  parameter int DUTY_W   = DEF_DUTY_W,
  parameter int STEP     = DEF_STEP,
  parameter int DEADTIME = DEF_DEADTIME
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [DUTY_W-1:0] i_target_a,
  input  logic [DUTY_W-1:0] i_target_b,
  input  logic [3:0]        i_dir_in,
  input  logic              i_estop,
  output logic [DUTY_W-1:0] o_duty_a,
  output logic [DUTY_W-1:0] o_duty_b,
  output logic [3:0]        o_dir_out,
  output logic              o_busy,
  output logic [1:0]        o_state_a,
  output logic [1:0]        o_state_b
);

  localparam logic [DUTY_W-1:0] PERIOD_V = DUTY_W'(PERIOD);

  logic [DUTY_W-1:0] r_tick_cnt;
  logic              r_busy;
  logic              w_tick;
  logic [DUTY_W-1:0] w_tgt_a;
  logic [DUTY_W-1:0] w_tgt_b;
  logic [DUTY_W-1:0] w_duty_a;
  logic [DUTY_W-1:0] w_duty_b;
  logic [1:0]        w_dir_a;
  logic [1:0]        w_dir_b;
  logic [1:0]        w_state_a;
  logic [1:0]        w_state_b;

  // PWM-period tick: counter runs 0..PERIOD, tick on the terminal count.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_tick_cnt <= '0;
    end else if (w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + DUTY_W'(1);
    end
  end

  assign w_tick = (r_tick_cnt == PERIOD_V);

  // Targets above the PWM terminal value cannot be produced, so clamp them.
  assign w_tgt_a = (i_target_a > PERIOD_V) ? PERIOD_V : i_target_a;
  assign w_tgt_b = (i_target_b > PERIOD_V) ? PERIOD_V : i_target_b;

  motor_ramp_channel #(
    .DUTY_W  (DUTY_W),
    .STEP    (STEP),
    .DEADTIME(DEADTIME)
  ) u_ch_a (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_tick (w_tick),
    .i_estop(i_estop),
    .i_tgt  (w_tgt_a),
    .i_dir  (i_dir_in[1:0]),
    .o_duty (w_duty_a),
    .o_dir  (w_dir_a),
    .o_state(w_state_a)
  );

  motor_ramp_channel #(
    .DUTY_W  (DUTY_W),
    .STEP    (STEP),
    .DEADTIME(DEADTIME)
  ) u_ch_b (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_tick (w_tick),
    .i_estop(i_estop),
    .i_tgt  (w_tgt_b),
    .i_dir  (i_dir_in[3:2]),
    .o_duty (w_duty_b),
    .o_dir  (w_dir_b),
    .o_state(w_state_b)
  );

  // busy: registered view of "either channel not yet settled on its target".
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_busy <= 1'b0;
    end else begin
      r_busy <= (w_state_a != ST_RUN) || (w_state_b != ST_RUN) ||
                (w_duty_a != w_tgt_a) || (w_duty_b != w_tgt_b);
    end
  end

  assign o_duty_a  = w_duty_a;
  assign o_duty_b  = w_duty_b;
  assign o_dir_out = {w_dir_b, w_dir_a};
  assign o_busy    = r_busy;
  assign o_state_a = w_state_a;
  assign o_state_b = w_state_b;

endmodule

// File: tb/tb_motor_ramp.sv
// Bench for motor_ramp with a short PWM period. Expected per-tick outputs
// {state_a, state_b, dir_out, duty_a, duty_b} are queued, then popped and
// compared after the DUT update edge.
module tb_motor_ramp;

  localparam int P   = 49;
  localparam int STP = 10;
  localparam int DT  = 2;
  localparam int DW  = 20;
  localparam int W   = 48;

  localparam logic [1:0] S_RUN  = 2'd0;
  localparam logic [1:0] S_BRK  = 2'd1;
  localparam logic [1:0] S_DEAD = 2'd2;

  // clock / reset / stimulus signals
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] target_a = '0;
  logic [DW-1:0] target_b = '0;
  logic [3:0]    dir_in = 4'b0000;
  logic          estop = 1'b0;
  logic [DW-1:0] duty_a;
  logic [DW-1:0] duty_b;
  logic [3:0]    dir_out;
  logic          busy;
  logic [1:0]    state_a;
  logic [1:0]    state_b;

  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];

  int   tb_cnt = 0;
  logic tb_tick_seen = 1'b0;

  always #5 clk = ~clk;

  motor_ramp #(
    .PERIOD  (P),
    .DUTY_W  (DW),
    .STEP    (STP),
    .DEADTIME(DT)
  ) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_target_a(target_a),
    .i_target_b(target_b),
    .i_dir_in  (dir_in),
    .i_estop   (estop),
    .o_duty_a  (duty_a),
    .o_duty_b  (duty_b),
    .o_dir_out (dir_out),
    .o_busy    (busy),
    .o_state_a (state_a),
    .o_state_b (state_b)
  );

  // Bench-side PWM period tracker: flags the edge on which updates land.
  always @(posedge clk) begin
    if (!rst_n) tb_cnt <= 0;
    else        tb_cnt <= (tb_cnt == P) ? 0 : tb_cnt + 1;
    tb_tick_seen <= rst_n && (tb_cnt == P);
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] pk(input logic [1:0] sa, input logic [1:0] sb,
                                      input logic [3:0] d, input int da, input int db);
    return {sa, sb, d, DW'(da), DW'(db)};
  endfunction

  task automatic pop_check(input string tag);
    logic [W-1:0] obs;
    obs = {state_a, state_b, dir_out, duty_a, duty_b};
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: scoreboard empty, got 0x%0h", tag, obs);
    end else begin
      check_eq(tag, 64'(obs), 64'(exp_q.pop_front()));
    end
  endtask

  // Wait for the next update edge, then sample 1 time unit later.
  task automatic next_tick();
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!tb_tick_seen && n < 2 * (P + 1));
    if (!tb_tick_seen) begin
      n_cmp++;
      n_err++;
      $display("FAIL tick_timeout: got %0d clocks without a tick, expected <= %0d", n, P + 1);
    end
  endtask

  task automatic tick_expect(input string tag, input logic [1:0] sa, input logic [1:0] sb,
                             input logic [3:0] d, input int da, input int db);
    exp_q.push_back(pk(sa, sb, d, da, db));
    next_tick();
    pop_check(tag);
  endtask

  task automatic expect_now(input string tag, input logic [1:0] sa, input logic [1:0] sb,
                            input logic [3:0] d, input int da, input int db);
    exp_q.push_back(pk(sa, sb, d, da, db));
    pop_check(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;

    // reset
    repeat (3) @(posedge clk);
    #1;
    expect_now("reset_out", S_RUN, S_RUN, 4'b0000, 0, 0);
    check_eq("reset_busy", 64'(busy), 64'd0);

    // start-up reversal to A=10, then ramp to 40
    dir_in   = 4'b0010;
    target_a = DW'(40);
    rst_n    = 1'b1;
    tick_expect("su_brake",  S_BRK,  S_RUN, 4'b0000, 0, 0);
    tick_expect("su_dead1",  S_DEAD, S_RUN, 4'b0000, 0, 0);
    tick_expect("su_dead2",  S_DEAD, S_RUN, 4'b0000, 0, 0);
    tick_expect("su_run",    S_RUN,  S_RUN, 4'b0010, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      tick_expect($sformatf("ramp_up_%0d", i), S_RUN, S_RUN, 4'b0010, 10 * i, 0);
      if (i >= 3) check_eq($sformatf("busy_ramp_%0d", i), 64'(busy), 64'd1);
    end
    @(posedge clk);
    #1;
    check_eq("busy_settled", 64'(busy), 64'd0);

    // reversal A 10 -> 01 at duty 40
    dir_in = 4'b0001;
    tick_expect("rev_enter", S_BRK, S_RUN, 4'b0010, 40, 0);
    for (int i = 1; i <= 3; i++)
      tick_expect($sformatf("rev_brake_%0d", i), S_BRK, S_RUN, 4'b0010, 40 - 10 * i, 0);
    tick_expect("rev_zero",  S_DEAD, S_RUN, 4'b0000, 0, 0);
    tick_expect("rev_dead",  S_DEAD, S_RUN, 4'b0000, 0, 0);
    tick_expect("rev_exit",  S_RUN,  S_RUN, 4'b0001, 0, 0);
    for (int i = 1; i <= 4; i++)
      tick_expect($sformatf("rev_ramp_%0d", i), S_RUN, S_RUN, 4'b0001, 10 * i, 0);

    // A ramps down to 0 in RUN, B clamps at the period ceiling
    target_a = '0;
    target_b = DW'(60);
    tick_expect("clamp_1", S_RUN, S_RUN, 4'b0001, 30, 10);
    tick_expect("clamp_2", S_RUN, S_RUN, 4'b0001, 20, 20);
    tick_expect("clamp_3", S_RUN, S_RUN, 4'b0001, 10, 30);
    tick_expect("clamp_4", S_RUN, S_RUN, 4'b0001, 0, 40);
    tick_expect("clamp_5", S_RUN, S_RUN, 4'b0001, 0, P);
    tick_expect("clamp_6", S_RUN, S_RUN, 4'b0001, 0, P);

    // small target below one step: reached in one tick, no overshoot
    target_a = DW'(7);
    tick_expect("small_1", S_RUN, S_RUN, 4'b0001, 7, P);
    tick_expect("small_2", S_RUN, S_RUN, 4'b0001, 7, P);
    check_eq("busy_clamped", 64'(busy), 64'd0);

    // estop mid-ramp, held across a tick
    target_a = DW'(40);
    tick_expect("pre_es_1", S_RUN, S_RUN, 4'b0001, 17, P);
    tick_expect("pre_es_2", S_RUN, S_RUN, 4'b0001, 27, P);
    estop = 1'b1;
    @(posedge clk);
    #1;
    expect_now("estop_now", S_DEAD, S_DEAD, 4'b0000, 0, 0);
    tick_expect("estop_hold", S_DEAD, S_DEAD, 4'b0000, 0, 0);
    estop = 1'b0;
    tick_expect("es_dead", S_DEAD, S_DEAD, 4'b0000, 0, 0);
    tick_expect("es_exit", S_RUN,  S_RUN,  4'b0001, 0, 0);
    tick_expect("es_ramp1", S_RUN, S_RUN, 4'b0001, 10, 10);
    tick_expect("es_ramp2", S_RUN, S_RUN, 4'b0001, 20, 20);

    // reset while A is braking
    dir_in   = 4'b0010;
    target_b = DW'(20);
    tick_expect("rb_brake1", S_BRK, S_RUN, 4'b0001, 20, 20);
    tick_expect("rb_brake2", S_BRK, S_RUN, 4'b0001, 10, 20);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    expect_now("rb_reset", S_RUN, S_RUN, 4'b0000, 0, 0);
    check_eq("rb_reset_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (state_a == S_RUN && n < 3 * (P + 1));
    check_eq("first_tick_clocks", 64'(n), 64'(P + 1));

    // A reverses while B ramps 0 -> 20 independently
    expect_now("sim_1", S_BRK, S_RUN, 4'b0000, 0, 10);
    tick_expect("sim_2", S_DEAD, S_RUN, 4'b0000, 0, 20);
    tick_expect("sim_3", S_DEAD, S_RUN, 4'b0000, 0, 20);
    tick_expect("sim_4", S_RUN,  S_RUN, 4'b0010, 0, 20);
    tick_expect("sim_5", S_RUN,  S_RUN, 4'b0010, 10, 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
